// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : in-order instruction fetch with credit-limited request issue,
//              response FIFO, redirect flush and misaligned-target fault.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready,
    output logic            fault
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   C_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic            fault_q, fault_d;
    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] tag_q   [DEPTH];

    logic [CW:0] w_inflight;
    logic        w_req_fire;
    logic        w_stale;
    logic        w_enq;
    logic        w_deq;

    // Stale requests stay in the outstanding count, so credit stays conservative.
    assign w_inflight     = {1'b0, outst_q} + {1'b0, cnt_q};
    assign imem_req_valid = !rst && !fault_q && !redirect_valid && (w_inflight < C_DEPTH);
    assign imem_req_addr  = pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_stale        = (drop_q != '0);
    assign w_enq          = imem_resp_valid && !w_stale && !redirect_valid;
    assign w_deq          = out_valid && out_ready && !redirect_valid;

    assign out_valid = (cnt_q != '0);
    assign out_instr = instr_q[head_q];
    assign out_pc    = tag_q[head_q];
    assign fault     = fault_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        fault_d = fault_q;
        outst_d = outst_q + CW'(w_req_fire) - CW'(imem_resp_valid);
        drop_d  = drop_q;
        cnt_d   = cnt_q + CW'(w_enq) - CW'(w_deq);
        head_d  = w_deq ? ptr_inc(head_q) : head_q;
        tail_d  = w_enq ? ptr_inc(tail_q) : tail_q;

        if (imem_resp_valid && w_stale) begin
            drop_d = drop_q - CW'(1);
        end
        if (w_req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
        // Responses return in order, so the tag is simply the next sequential PC.
        if (w_enq) begin
            rpc_d = rpc_q + XLEN'(4);
        end

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            rpc_d   = redirect_pc;
            fault_d = (redirect_pc[1:0] != 2'b00);
            drop_d  = outst_q - CW'(imem_resp_valid);
            cnt_d   = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            rpc_q   <= RESET_PC;
            fault_q <= 1'b0;
            outst_q <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            fault_q <= fault_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            instr_q[tail_q] <= imem_resp_data;
            tag_q[tail_q]   <= rpc_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;
    logic        fault;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_ready       (out_ready),
        .fault           (fault)
    );

    int          tests = 0;
    int          fails = 0;
    bit          resp_en;
    logic [63:0] req_log [$];
    logic [63:0] opc_log [$];
    logic [63:0] oin_log [$];
    logic [63:0] pend    [$];

    function automatic logic [31:0] word(input logic [63:0] a);
        return {8'hA0, a[23:0]};
    endfunction

    function automatic logic [63:0] qget(input logic [63:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: log handshakes at the falling edge, memory answers one cycle later.
    task automatic tick();
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            pend.push_back(imem_req_addr);
        end
        if (out_valid && out_ready) begin
            opc_log.push_back(out_pc);
            oin_log.push_back({32'h0, out_instr});
        end
        @(posedge clk);
        #1;
        if (resp_en && !rst && pend.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        imem_resp_valid = 1'b0;
        pend.delete();
        repeat (2) tick();
        pend.delete();
        req_log.delete();
        opc_log.delete();
        oin_log.delete();
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        resp_en        = 1'b1;

        // Reset state and streaming fetch
        do_reset();
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_fault", {63'h0, fault}, 64'h0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("first_req_addr", imem_req_addr, 64'h0);
        repeat (12) tick();
        for (int i = 0; i < 4; i++)
            chk($sformatf("seq_req%0d", i), qget(req_log, i), 64'(4 * i));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("seq_pc%0d", i), qget(opc_log, i), 64'(4 * i));
            chk($sformatf("seq_instr%0d", i), qget(oin_log, i), {32'h0, word(64'(4 * i))});
        end

        // Back-pressure: credit limits issue to two requests
        do_reset();
        out_ready = 1'b0;
        rst = 1'b0;
        repeat (10) tick();
        chk("bp_req_count", 64'(req_log.size()), 64'd2);
        chk("bp_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
        chk("bp_head_pc", out_pc, 64'h0);
        chk("bp_head_instr", {32'h0, out_instr}, {32'h0, word(64'h0)});
        out_ready = 1'b1;
        tick();
        chk("bp_pop_pc", qget(opc_log, 0), 64'h0);
        chk("bp_next_pc", out_pc, 64'h4);
        chk("bp_next_instr", {32'h0, out_instr}, {32'h0, word(64'h4)});

        // Redirect with two requests outstanding
        do_reset();
        resp_en = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk("rd_outst_req_count", 64'(req_log.size()), 64'd2);
        chk("rd_outst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        resp_en = 1'b1;
        req_log.delete();
        opc_log.delete();
        oin_log.delete();
        redirect(64'h28);
        chk("rd_plus1_out_valid", {63'h0, out_valid}, 64'h0);
        repeat (8) tick();
        chk("rd_first_req", qget(req_log, 0), 64'h28);
        chk("rd_first_out_pc", qget(opc_log, 0), 64'h28);
        chk("rd_first_out_instr", qget(oin_log, 0), {32'h0, word(64'h28)});
        chk("rd_second_out_pc", qget(opc_log, 1), 64'h2C);

        // Memory stall: address held, PC frozen
        do_reset();
        imem_req_ready = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_valid%0d", i), {63'h0, imem_req_valid}, 64'h1);
            chk($sformatf("stall_addr%0d", i), imem_req_addr, 64'h0);
        end
        chk("stall_no_handshake", 64'(req_log.size()), 64'd0);
        imem_req_ready = 1'b1;
        tick();
        chk("stall_release_req", qget(req_log, 0), 64'h0);
        chk("stall_release_next", imem_req_addr, 64'h4);

        // Misaligned redirect faults until an aligned redirect
        redirect(64'h2A);
        chk("flt_set", {63'h0, fault}, 64'h1);
        chk("flt_req_valid", {63'h0, imem_req_valid}, 64'h0);
        req_log.delete();
        repeat (5) tick();
        chk("flt_no_reqs", 64'(req_log.size()), 64'd0);
        chk("flt_hold", {63'h0, fault}, 64'h1);
        redirect(64'h40);
        chk("flt_clear", {63'h0, fault}, 64'h0);
        chk("flt_resume_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("flt_resume_addr", imem_req_addr, 64'h40);
        tick();
        chk("flt_resume_req", qget(req_log, 0), 64'h40);

        // PC wraps modulo 2^64
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        req_log.delete();
        opc_log.delete();
        oin_log.delete();
        repeat (8) tick();
        chk("wrap_req0", qget(req_log, 0), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_req1", qget(req_log, 1), 64'h0);
        chk("wrap_out_pc0", qget(opc_log, 0), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_out_instr0", qget(oin_log, 0), {32'h0, word(64'hFFFF_FFFF_FFFF_FFFC)});
        chk("wrap_out_pc1", qget(opc_log, 1), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
